// File: rtl/cos_arbiter_pkg.sv
// cos_arbiter_pkg
// Shared definitions for the cosine-engine arbiter: default sizing, the
// watchdog counter width and the 3-bit FSM state encoding.
package cos_arbiter_pkg;

  localparam int DEF_N   = 4;    // requesters sharing the engine
  localparam int DEF_W   = 16;   // angle / result width
  localparam int DEF_TMO = 255;  // watchdog limit in cycles
  localparam int WD_W    = 8;    // watchdog counter width

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/cos_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin selector. The search starts at ptr+1 (mod N)
// and returns the first requester found, so the last winner gets lowest
// priority on the next pick.
// Ports:
//   req - request vector (N bits)
//   ptr - index of the last served requester
//   any - at least one request present
//   idx - index of the selected requester (valid when any=1)
module rr_pick
  import cos_arbiter_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic         any,
  output logic [2:0]   idx
);

  always_comb begin
    any = |req;
    idx = '0;
    // Walk distances from farthest to nearest; the nearest hit is written
    // last and therefore wins.
    for (int k = N; k >= 1; k--) begin
      for (int j = 0; j < N; j++) begin
        if ((j == (int'(ptr) + k) % N) && req[j]) begin
          idx = 3'(j);
        end
      end
    end
  end

endmodule

// File: rtl/cos_arbiter.sv
// cos_arbiter
// Shares one handshake-driven cosine engine among N requesters. A request
// is granted round-robin in IDLE, the chosen angle is registered and the
// engine is started with a one-cycle strobe. The FSM then waits for the
// engine's done level to drop and rise again, captures the result and
// retires the request with a one-cycle ack. A watchdog aborts a stuck
// engine: the ack is still issued but res_valid stays low and err sticks.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req[N]              - request levels, held until ack
//   x_bus[N*W]          - packed angles, slice i belongs to requester i
//   ack[N]              - one-hot retire pulse
//   res[W], res_valid   - last good result and its qualifier
//   grant_id[3]         - current / last granted requester
//   busy, err           - not-IDLE indicator, sticky watchdog flag
//   eng_start, eng_x[W] - engine start strobe and registered angle
//   eng_done, eng_result- engine done level (high when idle) and result
module cos_arbiter
  import cos_arbiter_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int W   = DEF_W,
  parameter int TMO = DEF_TMO
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] x_bus,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   res,
  output logic           res_valid,
  output logic [2:0]     grant_id,
  output logic           busy,
  output logic           err,
  output logic           eng_start,
  output logic [W-1:0]   eng_x,
  input  logic           eng_done,
  input  logic [W-1:0]   eng_result
);

  localparam logic [WD_W-1:0] TMO_V = WD_W'(TMO);

  state_t          state_reg, state_next;
  logic [2:0]      ptr_reg, ptr_next;
  logic [2:0]      gid_reg, gid_next;
  logic [WD_W-1:0] wd_reg, wd_next;
  logic            err_reg, err_next;
  logic            to_reg, to_next;   // current transaction timed out
  logic [W-1:0]    res_reg, res_next;
  logic [W-1:0]    engx_reg, engx_next;

  logic            pick_any;
  logic [2:0]      pick_idx;
  logic [W-1:0]    x_sel;

  rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr_reg),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_idx == 3'(i)) x_sel = x_bus[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 3'(N - 1);
      gid_reg   <= '0;
      wd_reg    <= '0;
      err_reg   <= 1'b0;
      to_reg    <= 1'b0;
      res_reg   <= '0;
      engx_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gid_reg   <= gid_next;
      wd_reg    <= wd_next;
      err_reg   <= err_next;
      to_reg    <= to_next;
      res_reg   <= res_next;
      engx_reg  <= engx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    gid_next   = gid_reg;
    wd_next    = wd_reg;
    err_next   = err_reg;
    to_next    = to_reg;
    res_next   = res_reg;
    engx_next  = engx_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          gid_next   = pick_idx;
          engx_next  = x_sel;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_next    = '0;
        to_next    = 1'b0;
        state_next = WAIT_LO;
      end
      WAIT_LO: begin
        if (wd_reg == TMO_V) begin
          err_next   = 1'b1;
          to_next    = 1'b1;
          state_next = RESP;
        end else begin
          wd_next = wd_reg + 1'b1;
          if (!eng_done) state_next = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (wd_reg == TMO_V) begin
          err_next   = 1'b1;
          to_next    = 1'b1;
          state_next = RESP;
        end else begin
          wd_next = wd_reg + 1'b1;
          if (eng_done) begin
            res_next   = eng_result;
            state_next = RESP;
          end
        end
      end
      RESP: begin
        ptr_next   = gid_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ack is decoded from the registered grant so it can only be one-hot.
  for (genvar gi = 0; gi < N; gi++) begin : g_ack
    assign ack[gi] = (state_reg == RESP) && (gid_reg == 3'(gi));
  end

  assign res       = res_reg;
  assign res_valid = (state_reg == RESP) && !to_reg;
  assign grant_id  = gid_reg;
  assign busy      = (state_reg != IDLE);
  assign err       = err_reg;
  assign eng_start = (state_reg == LAUNCH);
  assign eng_x     = engx_reg;

endmodule

// File: doc/cos_arbiter.md
COS_ARBITER -- requirements
Module: cos_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters sharing one cosine engine (2..8).
REQ-002 SHALL have parameter W, default 16, meaning width of angle operand and cosine result.
REQ-003 SHALL have parameter TMO, default 255, meaning engine watchdog limit in cycles (8-bit).
REQ-004 SHALL have port clk, input, 1, meaning single clock; all logic is on the posedge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port req, input, N, meaning per-requester request level, held until ack.
REQ-007 SHALL have port x_bus, input, N*W, meaning packed angles; requester i uses bits [i*W+W-1 : i*W].
REQ-008 SHALL have port ack, output, N, meaning one-cycle retire pulse to the granted requester.
REQ-009 SHALL have port res, output, W, meaning last cosine result, valid when res_valid=1.
REQ-010 SHALL have port res_valid, output, 1, meaning res holds a good result; pulses with ack.
REQ-011 SHALL have port grant_id, output, 3, meaning index of the current or last granted requester.
REQ-012 SHALL have port busy, output, 1, meaning state is not IDLE.
REQ-013 SHALL have port err, output, 1, meaning sticky watchdog timeout flag.
REQ-014 SHALL have port eng_start, output, 1, meaning start strobe to the engine.
REQ-015 SHALL have port eng_x, output, W, meaning registered angle to the engine.
REQ-016 SHALL have port eng_done, input, 1, meaning engine done level (high while the engine is idle).
REQ-017 SHALL have port eng_result, input, W, meaning engine cosine output.

Function
REQ-018 SHALL implement FSM states IDLE, LAUNCH, WAIT_LO, WAIT_HI, RESP.
REQ-019 IDLE: if any req bit is 1, SHALL grant by round-robin starting at ptr+1 mod N, register grant_id and eng_x from the granted slice, and go to LAUNCH; otherwise SHALL stay in IDLE.
REQ-020 LAUNCH: SHALL drive eng_start=1 for exactly this one cycle and go to WAIT_LO.
REQ-021 WAIT_LO: SHALL wait for eng_done=0 (engine left idle), then go to WAIT_HI.
REQ-022 WAIT_HI: on eng_done=1, SHALL capture eng_result into res and go to RESP.
REQ-023 RESP: SHALL pulse ack[grant_id]=1 and res_valid=1 for one cycle, set ptr=grant_id, and go to IDLE.
REQ-024 Grant-to-ack latency SHALL be engine busy cycles + 4; back-to-back grants SHALL have one IDLE cycle between them.
REQ-025 req SHALL be sampled only in IDLE; a req deassert after grant SHALL NOT abort, and the ack SHALL still be issued.
REQ-026 eng_x SHALL stay stable from LAUNCH through RESP; x_bus changes after grant SHALL be ignored.
REQ-027 The watchdog counter SHALL clear on LAUNCH and increment in WAIT_LO and WAIT_HI.
REQ-028 When the watchdog reaches TMO, SHALL set err=1, go to RESP, and pulse ack with res_valid=0, leaving res unchanged.
REQ-029 With a single active requester, SHALL re-grant it every round; with all N active, each SHALL be served once per N grants.
REQ-030 ack and res_valid SHALL be 0 in all states other than RESP; ack SHALL be one-hot or zero.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, ptr=N-1, grant_id=0, watchdog=0, err=0, res=0, eng_x=0, and eng_start, ack, res_valid, busy all 0.
REQ-032 rst mid-operation SHALL abandon the transaction with no ack; the engine SHALL be reset by the same rst.

Structure
REQ-033 A shared package SHALL hold the state encoding (3-bit), the default W, N, and TMO values, and the watchdog width.
REQ-034 The round-robin priority pick SHALL be a sub-module rr_pick (inputs req, ptr; outputs any, idx).

Verification
REQ-035 Reset then req=0001, x0=16'h0000, engine model busy 10 cycles -> eng_start 1 cycle after grant; ack=0001 and res=engine value 14 cycles after grant.
REQ-036 req=1111 held, 8 rounds -> grant_id sequence 0,1,2,3,0,1,2,3; exactly one ack per requester per 4 grants.
REQ-037 req=0100, x_bus slice changed from 16'h1000 to 16'h2000 during WAIT_HI -> eng_x stays 16'h1000 through RESP.
REQ-038 Engine model holds eng_done=0 forever -> err=1 and ack pulses with res_valid=0 at TMO+3 cycles after grant; FSM returns to IDLE.
REQ-039 rst asserted in WAIT_HI -> next cycle IDLE, busy=0, no ack, ptr=N-1, so requester 0 wins the next grant.
REQ-040 req=0010 dropped in the cycle after grant -> ack=0010 still pulses once; no further grant issued.
